div_iter: RTL



---
 rtl/div_iter_pkg.sv | 13 +
 rtl/div_iter_if.sv | 25 ++
 rtl/div_iter_step.sv | 26 ++
 rtl/div_iter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_iter_pkg;

   localparam int unsigned DIV_ITER = 32;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StDivZero = 2'd1,
      StBusy    = 2'd2,
      StDone    = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_iter_if.sv
// Divide handshake between the ALU (master) and the iterative divider (slave).
interface div_iter_if
   import div_iter_pkg::*;
#(
   parameter int unsigned DATA_W = DIV_ITER
);
   logic                  signed_div;
   logic [DATA_W-1:0]     a;
   logic [DATA_W-1:0]     b;
   logic                  start;
   logic                  annul;
   logic [2*DATA_W-1:0]   result;
   logic                  ready;
   logic                  div_by_zero;

   modport master (
      output signed_div, a, b, start, annul,
      input  result, ready, div_by_zero
   );

   modport slave (
      input  signed_div, a, b, start, annul,
      output result, ready, div_by_zero
   );
endinterface

// File: rtl/div_iter_step.sv
// One radix-2 restoring iteration on the {partial_rem, dividend} working register.
module div_iter_step
   import div_iter_pkg::*;
#(
   parameter int unsigned DATA_W = DIV_ITER
) (
   input  logic [2*DATA_W:0]   work_i,
   input  logic [DATA_W-1:0]   divisor_i,
   output logic [2*DATA_W:0]   work_o
);

   logic [2*DATA_W+1:0] shifted;
   logic [DATA_W+1:0]   diff;

   always_comb begin
      shifted = {work_i, 1'b0};
      // Extra top bit makes the borrow of the trial subtraction visible as a sign.
      diff    = shifted[2*DATA_W+1:DATA_W] - {2'b00, divisor_i};
      if (diff[DATA_W+1]) begin
         work_o = shifted[2*DATA_W:0];
      end else begin
         work_o = {diff[DATA_W:0], shifted[DATA_W-1:1], 1'b1};
      end
   end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider; answers the ALU divide handshake with
// {remainder, quotient} after DATA_W+1 cycles, or 2 cycles for a zero divisor.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int unsigned DATA_W = DIV_ITER,
   parameter int unsigned CNT_W  = 6
) (
   input  logic         clk,
   input  logic         rst,
   div_iter_if.slave    bus
);

   div_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*DATA_W:0]   work_q, work_d;
   logic [DATA_W-1:0]   divisor_q, divisor_d;
   logic                q_neg_q, q_neg_d;
   logic                r_neg_q, r_neg_d;
   logic [2*DATA_W-1:0] result_q, result_d;
   logic                ready_q, ready_d;
   logic                dbz_q, dbz_d;

   logic [2*DATA_W:0]   work_step;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic [DATA_W-1:0]   quo_fix, rem_fix;

   div_iter_step #(
      .DATA_W (DATA_W)
   ) u_step (
      .work_i    (work_q),
      .divisor_i (divisor_q),
      .work_o    (work_step)
   );

   // abs() of the most negative value wraps to itself and is then used unsigned.
   always_comb begin
      a_mag = (bus.signed_div && bus.a[DATA_W-1]) ? (~bus.a + DATA_W'(1)) : bus.a;
      b_mag = (bus.signed_div && bus.b[DATA_W-1]) ? (~bus.b + DATA_W'(1)) : bus.b;
   end

   always_comb begin
      quo_fix = q_neg_q ? (~work_q[DATA_W-1:0] + DATA_W'(1)) : work_q[DATA_W-1:0];
      rem_fix = r_neg_q ? (~work_q[2*DATA_W-1:DATA_W] + DATA_W'(1))
                        : work_q[2*DATA_W-1:DATA_W];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      result_d  = result_q;
      ready_d   = 1'b0;
      dbz_d     = dbz_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start && !bus.annul) begin
               work_d    = {{(DATA_W+1){1'b0}}, a_mag};
               divisor_d = b_mag;
               q_neg_d   = bus.signed_div & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
               r_neg_d   = bus.signed_div & bus.a[DATA_W-1];
               cnt_d     = '0;
               dbz_d     = 1'b0;
               state_d   = (bus.b == '0) ? StDivZero : StBusy;
            end
         end
         StDivZero: begin
            state_d = bus.annul ? StIdle : StDone;
         end
         StBusy: begin
            if (bus.annul) begin
               state_d = StIdle;
            end else begin
               work_d = work_step;
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            ready_d = 1'b1;
            if (divisor_q == '0) begin
               result_d = '0;
               dbz_d    = 1'b1;
            end else begin
               result_d = {rem_fix, quo_fix};
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         result_q  <= '0;
         ready_q   <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
         dbz_q     <= dbz_d;
      end
   end

   assign bus.result      = result_q;
   assign bus.ready       = ready_q;
   assign bus.div_by_zero = dbz_q;

endmodule
